// File: rtl/dac_segment_encoder_pkg.sv
// rtl/dac_segment_encoder_pkg.sv - shared types, widths and the midscale pattern for the segment encoder
package dac_seg_pkg;
  localparam int MSB_W  = 4;
  localparam int LSB_W  = 6;
  localparam int NT     = 2**MSB_W;
  localparam int CODE_W = MSB_W + LSB_W;

  typedef enum logic [1:0] {OFF, WAKE, RUN} enc_state_t;

  // Lower half of the rotating cells plus the always-on offset cell.
  function automatic logic [NT:0] midscale_therm();
    logic [NT:0] t;
    t = '0;
    for (int i = 0; i < NT/2; i++) t[i] = 1'b1;
    t[NT] = 1'b1;
    return t;
  endfunction
endpackage

// File: rtl/dac_segment_encoder_if.sv
// rtl/dac_segment_encoder_if.sv - code input handshake and cell-select outputs of the segment encoder
interface dac_segment_encoder_if;
  import dac_seg_pkg::*;

  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              dem_ena;
  logic              lsb_red_sel;
  logic [NT:0]       therm_sel;
  logic [LSB_W-1:0]  bin_sel;
  logic              bin0_red_sel;
  logic              enc_ready;
  logic [MSB_W-1:0]  dem_ptr;

  modport master (output code_in, code_valid, dem_ena, lsb_red_sel,
                  input  therm_sel, bin_sel, bin0_red_sel, enc_ready, dem_ptr);
  modport slave  (input  code_in, code_valid, dem_ena, lsb_red_sel,
                  output therm_sel, bin_sel, bin0_red_sel, enc_ready, dem_ptr);
endinterface

// File: rtl/dac_segment_encoder_dem_rotator.sv
// rtl/dac_segment_encoder_dem_rotator.sv - m-cell thermometer mask starting at ptr, wrapping modulo NT
module dac_dem_rotator
  import dac_seg_pkg::*;
(
  input  logic [MSB_W-1:0] m_i,
  input  logic [MSB_W-1:0] ptr_i,
  output logic [NT-1:0]    mask_o
);
  // Cell i is on when its distance from ptr (mod NT) is below m.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < NT; i++) begin
      mask_o[i] = (MSB_W'(i) - ptr_i) < m_i;
    end
  end
endmodule

// File: rtl/dac_segment_encoder.sv
// rtl/dac_segment_encoder.sv - pdb sequencing FSM, DEM pointer and 2-stage segment decode pipeline
module dac_segment_encoder
  import dac_seg_pkg::*;
#(
  parameter int WAKE_CYC    = 16,
  parameter int SYNC_STAGES = 2
)(
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  pdb,
  dac_segment_encoder_if.slave  bus
);
  localparam int WCNT_W = $clog2(WAKE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pdb_s;
  enc_state_t             state_q, state_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic [MSB_W-1:0]       dem_ptr_q, dem_ptr_d;
  logic                   go_off, accept;
  logic [MSB_W-1:0]       m_in;
  logic [LSB_W-1:0]       l_in;

  logic                   s1_vld_q;
  logic [MSB_W-1:0]       s1_m_q, s1_ptr_q;
  logic [LSB_W-1:0]       s1_l_q;
  logic                   s1_red_q;

  logic [NT-1:0]          mask;
  logic [LSB_W-1:0]       bin_d;
  logic                   bred_d;
  logic [NT:0]            therm_q;
  logic [LSB_W-1:0]       bin_q;
  logic                   bred_q;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pdb};
  end
  assign pdb_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      OFF: begin
        wcnt_d = '0;
        if (pdb_s) state_d = WAKE;
      end
      WAKE: begin
        if (!pdb_s) begin
          state_d = OFF;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_W'(WAKE_CYC - 1)) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      RUN:     if (!pdb_s) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  // A sample coinciding with the RUN->OFF edge is dropped because go_off wins.
  assign go_off = (state_q != OFF) && !pdb_s;
  assign accept = bus.code_valid && (state_q == RUN) && pdb_s;
  assign m_in   = bus.code_in[CODE_W-1:LSB_W];
  assign l_in   = bus.code_in[LSB_W-1:0];

  always_comb begin
    dem_ptr_d = dem_ptr_q;
    if (go_off)      dem_ptr_d = '0;
    else if (accept) dem_ptr_d = bus.dem_ena ? dem_ptr_q + m_in : '0;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      dem_ptr_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_m_q    <= '0;
      s1_ptr_q  <= '0;
      s1_l_q    <= '0;
      s1_red_q  <= 1'b0;
    end else begin
      dem_ptr_q <= dem_ptr_d;
      if (go_off) begin
        s1_vld_q <= 1'b0;
        s1_m_q   <= '0;
        s1_ptr_q <= '0;
        s1_l_q   <= '0;
        s1_red_q <= 1'b0;
      end else begin
        s1_vld_q <= accept;
        if (accept) begin
          s1_m_q   <= m_in;
          s1_ptr_q <= bus.dem_ena ? dem_ptr_q : '0;
          s1_l_q   <= l_in;
          s1_red_q <= bus.lsb_red_sel;
        end
      end
    end
  end

  dac_dem_rotator u_rot (
    .m_i    (s1_m_q),
    .ptr_i  (s1_ptr_q),
    .mask_o (mask)
  );

  always_comb begin
    bin_d  = s1_l_q;
    bred_d = 1'b0;
    if (s1_red_q) begin
      bin_d[0] = 1'b0;
      bred_d   = s1_l_q[0];
    end
  end

  // S2 preloads midscale during WAKE so RUN starts from that pattern until the first sample lands.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      therm_q <= '0;
      bin_q   <= '0;
      bred_q  <= 1'b0;
    end else if (go_off) begin
      therm_q <= '0;
      bin_q   <= '0;
      bred_q  <= 1'b0;
    end else if (state_q == WAKE) begin
      therm_q <= midscale_therm();
      bin_q   <= '0;
      bred_q  <= 1'b0;
    end else if (s1_vld_q) begin
      therm_q <= {1'b1, mask};
      bin_q   <= bin_d;
      bred_q  <= bred_d;
    end
  end

  assign bus.therm_sel    = (state_q == WAKE) ? midscale_therm() : therm_q;
  assign bus.bin_sel      = bin_q;
  assign bus.bin0_red_sel = bred_q;
  assign bus.enc_ready    = (state_q == RUN);
  assign bus.dem_ptr      = dem_ptr_q;
endmodule

// File: tb/tb_dac_segment_encoder.sv
// tb/tb_dac_segment_encoder.sv - directed table-driven bench for dac_segment_encoder and dac_dem_rotator
module tb_dac_segment_encoder;
  logic clk = 1'b0;
  logic rst;
  logic pdb;
  int   n_run  = 0;
  int   n_fail = 0;

  dac_segment_encoder_if bus();

  dac_segment_encoder #(.WAKE_CYC(16), .SYNC_STAGES(2)) dut (
    .clkin (clk),
    .rst   (rst),
    .pdb   (pdb),
    .bus   (bus)
  );

  logic [3:0]  rot_m, rot_ptr;
  logic [15:0] rot_mask;
  dac_dem_rotator u_rot_ut (.m_i(rot_m), .ptr_i(rot_ptr), .mask_o(rot_mask));

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  code;
    logic        dem;
    logic        red;
    logic [16:0] therm;
    logic [5:0]  bin;
    logic        bred;
    logic [3:0]  ptr;
  } vec_t;

  typedef struct {
    logic [3:0]  m;
    logic [3:0]  ptr;
    logic [15:0] mask;
  } rot_t;

  vec_t vecs[8];
  rot_t rots[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_therm"}, 32'(bus.therm_sel), 32'h0);
    chk({name, "_bin"},   32'(bus.bin_sel), 32'h0);
    chk({name, "_bred"},  32'(bus.bin0_red_sel), 32'h0);
    chk({name, "_ptr"},   32'(bus.dem_ptr), 32'h0);
    chk({name, "_ready"}, 32'(bus.enc_ready), 32'h0);
  endtask

  task automatic wait_run(input string name);
    for (int i = 0; i < 40 && !bus.enc_ready; i++) tick();
    chk(name, 32'(bus.enc_ready), 32'h1);
  endtask

  initial begin
    vecs[0] = '{10'h2A5, 1'b0, 1'b0, 17'h103FF, 6'h25, 1'b0, 4'd0};
    vecs[1] = '{10'h1C0, 1'b1, 1'b0, 17'h1007F, 6'h00, 1'b0, 4'd7};
    vecs[2] = '{10'h1C0, 1'b1, 1'b0, 17'h13F80, 6'h00, 1'b0, 4'd14};
    vecs[3] = '{10'h1C0, 1'b1, 1'b0, 17'h1C01F, 6'h00, 1'b0, 4'd5};
    vecs[4] = '{10'h001, 1'b1, 1'b1, 17'h10000, 6'h00, 1'b1, 4'd5};
    vecs[5] = '{10'h001, 1'b0, 1'b0, 17'h10000, 6'h01, 1'b0, 4'd0};
    vecs[6] = '{10'h3FF, 1'b1, 1'b0, 17'h17FFF, 6'h3F, 1'b0, 4'd15};
    vecs[7] = '{10'h082, 1'b1, 1'b1, 17'h18001, 6'h02, 1'b0, 4'd1};
    rots[0] = '{4'd0,  4'd5,  16'h0000};
    rots[1] = '{4'd3,  4'd14, 16'hC001};
    rots[2] = '{4'd15, 4'd1,  16'hFFFE};
    rots[3] = '{4'd1,  4'd15, 16'h8000};

    for (int i = 0; i < 4; i++) begin
      rot_m = rots[i].m;
      rot_ptr = rots[i].ptr;
      #1;
      chk($sformatf("rot%0d", i), 32'(rot_mask), 32'(rots[i].mask));
    end

    rst = 1'b1;
    pdb = 1'b0;
    bus.code_in = '0;
    bus.code_valid = 1'b0;
    bus.dem_ena = 1'b0;
    bus.lsb_red_sel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");

    for (int i = 0; i < 50; i++) begin
      bus.code_valid = i[0];
      bus.code_in = 10'($urandom);
      tick();
      chk("off_idle", {bus.therm_sel, bus.bin_sel, bus.bin0_red_sel, bus.enc_ready, bus.dem_ptr}, 32'h0);
    end
    bus.code_valid = 1'b0;

    pdb = 1'b1;
    tick();
    chk("sync1_off", 32'(bus.therm_sel), 32'h0);
    tick();
    chk("sync2_off", 32'(bus.therm_sel), 32'h0);
    tick();
    chk("wake_mid", 32'(bus.therm_sel), 32'h100FF);
    chk("wake_ready", 32'(bus.enc_ready), 32'h0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("wake_cnt%0d", k), 32'(bus.enc_ready), 32'h0);
    end
    tick();
    chk("run_ready", 32'(bus.enc_ready), 32'h1);
    chk("run_mid", 32'(bus.therm_sel), 32'h100FF);

    for (int v = 0; v < 8; v++) begin
      bus.code_in = vecs[v].code;
      bus.dem_ena = vecs[v].dem;
      bus.lsb_red_sel = vecs[v].red;
      bus.code_valid = 1'b1;
      tick();
      bus.code_valid = 1'b0;
      tick();
      for (int h = 0; h < 2; h++) begin
        chk($sformatf("v%0d_therm_h%0d", v, h), 32'(bus.therm_sel), 32'(vecs[v].therm));
        chk($sformatf("v%0d_bin_h%0d", v, h), 32'(bus.bin_sel), 32'(vecs[v].bin));
        chk($sformatf("v%0d_bred_h%0d", v, h), 32'(bus.bin0_red_sel), 32'(vecs[v].bred));
        chk($sformatf("v%0d_ptr_h%0d", v, h), 32'(bus.dem_ptr), 32'(vecs[v].ptr));
        bus.dem_ena = ~bus.dem_ena;
        tick();
      end
    end

    // Back-to-back m=7 from pointer 0.
    bus.code_in = 10'h001; bus.dem_ena = 1'b0; bus.lsb_red_sel = 1'b0; bus.code_valid = 1'b1;
    tick();
    bus.code_in = 10'h1C0; bus.dem_ena = 1'b1;
    tick();
    chk("b2b_ptr1", 32'(bus.dem_ptr), 32'd7);
    tick();
    chk("b2b_ptr2", 32'(bus.dem_ptr), 32'd14);
    chk("b2b_mask1", 32'(bus.therm_sel), 32'h1007F);
    tick();
    bus.code_valid = 1'b0;
    chk("b2b_ptr3", 32'(bus.dem_ptr), 32'd5);
    chk("b2b_mask2", 32'(bus.therm_sel), 32'h13F80);
    tick();
    chk("b2b_mask3", 32'(bus.therm_sel), 32'h1C01F);

    // pdb falls while samples keep streaming.
    bus.code_valid = 1'b1;
    pdb = 1'b0;
    tick();
    tick();
    chk("pdn_still_run", 32'(bus.enc_ready), 32'h1);
    tick();
    chk_zero("pdn_off");
    bus.code_valid = 1'b0;

    pdb = 1'b1;
    wait_run("rerun");
    bus.code_in = 10'h2A5; bus.dem_ena = 1'b0; bus.code_valid = 1'b1;
    tick();
    bus.code_valid = 1'b0;
    tick();
    chk("pre_rst_therm", 32'(bus.therm_sel), 32'h103FF);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
